// File: rtl/spi_mem_pkg.sv
// Shared types and helpers for the SPI burst memory.
// Holds FSM states, SCLK edge selection and frame length.
package spi_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WRITE_DATA,
        READ_DATA
    } state_t;

    // Data is sampled on SCLK rise when CPOL equals CPHA.
    function automatic bit sample_on_rise(input int cpol, input int cpha);
        return cpol == cpha;
    endfunction

    function automatic bit shift_on_rise(input int cpol, input int cpha);
        return cpol != cpha;
    endfunction

    // Command frame: address bits followed by one R/W bit.
    function automatic int frame_len(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/spi_input_conditioner.sv
// Synchroniser for one asynchronous pin plus edge pulses.
// Ports: clk, reset (sync, active-high), pin in;
//        level (synchronised), rise/fall (1-clk pulses) out.
module spi_input_conditioner #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{INIT}};
            prev_q <= INIT;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_memory_burst.sv
// SPI-slave register memory with burst auto-increment, all SPI modes.
// Ports: clk, reset (sync, active-high), sclk_pin, cs_pin (active low),
//        mosi_pin in; miso_pin (z outside reads), leds[3:0] out.
module spi_memory_burst
    import spi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic [3:0] leds
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int FRAME = frame_len(ADDR_WIDTH);
    localparam int RXW   = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW    = $clog2(RXW + 1);
    localparam bit SRISE = sample_on_rise(CPOL, CPHA);
    localparam bit HRISE = shift_on_rise(CPOL, CPHA);

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic cs_lvl, cs_fall, cs_rise_unused;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_input_conditioner #(.STAGES(SYNC_STAGES), .INIT(1'(CPOL))) u_sclk (
        .clk(clk), .reset(reset), .pin(sclk_pin),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_input_conditioner #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
        .clk(clk), .reset(reset), .pin(cs_pin),
        .level(cs_lvl), .rise(cs_rise_unused), .fall(cs_fall)
    );

    spi_input_conditioner #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .pin(mosi_pin),
        .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    logic sample_edge, shift_edge;
    assign sample_edge = SRISE ? sclk_rise : sclk_fall;
    assign shift_edge  = HRISE ? sclk_rise : sclk_fall;

    state_t                  state_q, state_d;
    logic [CW-1:0]           bit_cnt_q;
    logic [RXW-1:0]          rx_q;
    logic [DATA_WIDTH-1:0]   tx_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    miso_q;
    logic                    load_q;
    logic [3:0]              leds_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    frame_done, word_done;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [3:0]              led_word;

    assign wdata = {rx_q[DATA_WIDTH-2:0], mosi_lvl};

    if (DATA_WIDTH >= 4) begin : g_led_wide
        assign led_word = wdata[3:0];
    end else begin : g_led_narrow
        assign led_word = {{(4-DATA_WIDTH){1'b0}}, wdata};
    end

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        word_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) state_d = CMD;
            end
            CMD: begin
                if (sample_edge && bit_cnt_q == CW'(FRAME - 1)) begin
                    frame_done = 1'b1;
                    state_d    = mosi_lvl ? READ_DATA : WRITE_DATA;
                end
            end
            WRITE_DATA, READ_DATA: begin
                if (sample_edge && bit_cnt_q == CW'(DATA_WIDTH - 1))
                    word_done = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Deasserted chip select overrides everything, including a
        // last-bit sample edge landing in the same cycle.
        if (cs_lvl) begin
            state_d    = IDLE;
            frame_done = 1'b0;
            word_done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            miso_q    <= 1'b0;
            load_q    <= 1'b0;
            leds_q    <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= 1'b0;
            if (cs_lvl || state_q == IDLE) begin
                bit_cnt_q <= '0;
            end else if (sample_edge) begin
                rx_q      <= {rx_q[RXW-2:0], mosi_lvl};
                bit_cnt_q <= (frame_done || word_done) ? '0
                                                       : bit_cnt_q + CW'(1);
            end
            if (state_q == READ_DATA && !cs_lvl && shift_edge) begin
                miso_q <= tx_q[DATA_WIDTH-1];
                tx_q   <= {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
            if (frame_done) begin
                addr_q <= rx_q[ADDR_WIDTH-1:0];
                load_q <= 1'b1;
                miso_q <= 1'b0;
            end
            if (word_done) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                load_q <= (state_q == READ_DATA);
            end
            if (word_done && state_q == WRITE_DATA)
                leds_q <= led_word;
            // Prefetch one cycle after the address settles.
            if (load_q)
                tx_q <= mem[addr_q];
        end
    end

    // Memory is deliberately not reset so contents survive it.
    always_ff @(posedge clk) begin
        if (!reset && word_done && state_q == WRITE_DATA)
            mem[addr_q] <= wdata;
    end

    assign miso_pin = (state_q == READ_DATA) ? miso_q : 1'bz;
    assign leds     = leds_q;

endmodule

// File: tb/tb_spi_memory_burst.sv
// Randomised scoreboard bench for spi_memory_burst.
// Three instances: mode 0, mode 3, and 4-bit addr/16-bit data mode 2.
module tb_spi_memory_burst;

    localparam int HALF = 70;

    typedef struct packed {
        logic [1:0]  inst;
        logic [31:0] word;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sclk_p [3];
    logic cs_p   [3];
    logic mosi_p [3];
    wire  miso0, miso1, miso2;
    wire  [3:0] leds0, leds1, leds2;
    wire  mz0 = (miso0 === 1'bz);
    wire  mz1 = (miso1 === 1'bz);
    wire  mz2 = (miso2 === 1'bz);

    int   aws [3] = '{7, 7, 4};
    int   dws [3] = '{8, 8, 16};
    logic cpa [3] = '{1'b0, 1'b1, 1'b1};
    logic cha [3] = '{1'b0, 1'b1, 1'b0};

    logic [31:0] wbuf  [16];
    logic [31:0] model [3][128];
    logic [3:0]  led_m [3];
    rec_t        exp_q [$];
    rec_t        obs_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    spi_memory_burst #(.ADDR_WIDTH(7), .DATA_WIDTH(8),
                       .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset(reset), .sclk_pin(sclk_p[0]), .cs_pin(cs_p[0]),
        .mosi_pin(mosi_p[0]), .miso_pin(miso0), .leds(leds0)
    );

    spi_memory_burst #(.ADDR_WIDTH(7), .DATA_WIDTH(8),
                       .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset(reset), .sclk_pin(sclk_p[1]), .cs_pin(cs_p[1]),
        .mosi_pin(mosi_p[1]), .miso_pin(miso1), .leds(leds1)
    );

    spi_memory_burst #(.ADDR_WIDTH(4), .DATA_WIDTH(16),
                       .CPOL(1), .CPHA(0), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .reset(reset), .sclk_pin(sclk_p[2]), .cs_pin(cs_p[2]),
        .mosi_pin(mosi_p[2]), .miso_pin(miso2), .leds(leds2)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic logic miso_of(input int i);
        case (i)
            0:       return miso0;
            1:       return miso1;
            default: return miso2;
        endcase
    endfunction

    function automatic logic z_of(input int i);
        case (i)
            0:       return mz0;
            1:       return mz1;
            default: return mz2;
        endcase
    endfunction

    function automatic logic [3:0] leds_of(input int i);
        case (i)
            0:       return leds0;
            1:       return leds1;
            default: return leds2;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(input int i);
        return (dws[i] >= 32) ? 32'hffff_ffff : ((32'h1 << dws[i]) - 32'h1);
    endfunction

    // One SPI bit as a mode-aware master; r is miso at the sample edge.
    task automatic xfer(input int i, input logic b, output logic r);
        if (!cha[i]) begin
            mosi_p[i] = b;
            #HALF;
            sclk_p[i] = ~cpa[i];
            r = miso_of(i);
            #HALF;
            sclk_p[i] = cpa[i];
        end else begin
            sclk_p[i] = ~cpa[i];
            mosi_p[i] = b;
            #HALF;
            sclk_p[i] = cpa[i];
            r = miso_of(i);
            #HALF;
        end
    endtask

    // cut >= 0 raises cs after that many data bits; rst_mid pulses reset.
    task automatic frame(input int i, input int addr, input bit rd,
                         input int nw, input int cut, input bit rst_mid);
        int aw, dw, depth, full, total;
        logic r;
        logic [31:0] word;
        aw    = aws[i];
        dw    = dws[i];
        depth = 1 << aw;
        total = (cut < 0) ? nw * dw : cut;
        full  = rst_mid ? 0 : total / dw;
        if (rd)
            for (int w = 0; w < full; w++)
                exp_q.push_back(rec_t'{inst: 2'(i),
                                       word: model[i][(addr + w) % depth]});
        cs_p[i] = 1'b0;
        #HALF;
        for (int b = aw - 1; b >= 0; b--) begin
            xfer(i, addr[b], r);
            if (b == aw / 2) check("miso_z_cmd", 32'(z_of(i)), 32'd1);
        end
        check("miso_z_pre_rw", 32'(z_of(i)), 32'd1);
        xfer(i, rd, r);
        word = '0;
        for (int k = 0; k < total; k++) begin
            xfer(i, wbuf[k / dw][dw - 1 - (k % dw)], r);
            word = {word[30:0], r};
            if (k % dw == dw - 1) begin
                if (rd) obs_q.push_back(rec_t'{inst: 2'(i), word: word});
                word = '0;
            end
            if (rst_mid && k == dw / 2) begin
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    check("miso_z_after_reset", 32'(z_of(j)), 32'd1);
                    check("leds_after_reset", 32'(leds_of(j)), 32'd0);
                    led_m[j] = 4'h0;
                end
                break;
            end
        end
        #HALF;
        cs_p[i] = 1'b1;
        repeat (5) @(negedge clk);
        check("miso_z_end", 32'(z_of(i)), 32'd1);
        if (!rd)
            for (int w = 0; w < full; w++) begin
                model[i][(addr + w) % depth] = wbuf[w] & mask_of(i);
                led_m[i] = wbuf[w][3:0];
            end
        check("leds", 32'(leds_of(i)), 32'(led_m[i]));
    endtask

    task automatic cs_high_noise(input int i);
        mosi_p[i] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            sclk_p[i] = ~cpa[i];
            #HALF;
            sclk_p[i] = cpa[i];
            #HALF;
            if (c % 4 == 0) check("miso_z_cs_high", 32'(z_of(i)), 32'd1);
        end
        mosi_p[i] = 1'b0;
        check("leds_cs_high", 32'(leds_of(i)), 32'(led_m[i]));
    endtask

    // Monitor: pairs every observed read word with the next expectation.
    initial begin
        rec_t o, e;
        forever begin
            @(posedge clk);
            while (obs_q.size() != 0) begin
                o = obs_q.pop_front();
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rd_unexpected: got %0h, expected none",
                             o.word);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_inst", 32'(o.inst), 32'(e.inst));
                    check("rd_word", o.word, e.word);
                end
            end
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, n, depth;
        for (int i = 0; i < 3; i++) begin
            cs_p[i]   = 1'b1;
            sclk_p[i] = cpa[i];
            mosi_p[i] = 1'b0;
            led_m[i]  = 4'h0;
        end
        #3;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_leds", 32'(leds_of(i)), 32'd0);
            check("rst_miso_z", 32'(z_of(i)), 32'd1);
        end

        // Single write then read back, per mode/geometry.
        for (int i = 0; i < 3; i++) begin
            wbuf[0] = (i == 2) ? 32'hBEEF : 32'h3C;
            frame(i, 5, 1'b0, 1, -1, 1'b0);
            frame(i, 5, 1'b1, 1, -1, 1'b0);
        end

        // Burst across the top of the address space.
        for (int i = 0; i < 3; i++) begin
            depth = 1 << aws[i];
            wbuf[0] = 32'hA1;
            wbuf[1] = 32'hB2;
            wbuf[2] = 32'hC3;
            frame(i, depth - 2, 1'b0, 3, -1, 1'b0);
            frame(i, depth - 2, 1'b1, 3, -1, 1'b0);
            frame(i, 0, 1'b1, 1, -1, 1'b0);
        end

        // Aborted partial write must leave memory untouched.
        for (int i = 0; i < 3; i++) begin
            wbuf[0] = 32'hFFFF;
            frame(i, 'h10 % (1 << aws[i]), 1'b0, 1, -1, 1'b0);
            wbuf[0] = 32'h0;
            frame(i, 'h10 % (1 << aws[i]), 1'b0, 1, 5, 1'b0);
            frame(i, 'h10 % (1 << aws[i]), 1'b1, 1, -1, 1'b0);
            wbuf[0] = 32'h5A;
            frame(i, 3, 1'b0, 1, -1, 1'b0);
            frame(i, 3, 1'b1, 1, -1, 1'b0);
        end

        // Bus activity with cs high is ignored.
        for (int i = 0; i < 3; i++) begin
            cs_high_noise(i);
            frame(i, 5, 1'b1, 1, -1, 1'b0);
        end

        // Reset during a read, then memory still holds its data.
        frame(0, 5, 1'b1, 1, -1, 1'b1);
        frame(0, 5, 1'b1, 1, -1, 1'b0);
        frame(2, 3, 1'b1, 1, -1, 1'b0);

        // Random bursts with read-back.
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 3; i++) begin
                depth = 1 << aws[i];
                a = int'($urandom_range(depth - 1));
                n = int'($urandom_range(4, 1));
                for (int w = 0; w < n; w++) wbuf[w] = $urandom;
                frame(i, a, 1'b0, n, -1, 1'b0);
                frame(i, a, 1'b1, n, -1, 1'b0);
            end
        end

        repeat (20) @(negedge clk);
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        check("obs_drained", 32'(obs_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
